// File: rtl/ori_hist_peak.sv
// ori_hist_peak: accumulates magnitude-weighted 5-bit direction bins into a
// 32-entry saturating histogram over one keypoint window, then scans it and
// reports the peak bin (lowest index wins ties) and its value.
module ori_hist_peak #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_dir,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_last,
    output logic             busy,
    output logic             out_valid,
    output logic [4:0]       out_dir,
    output logic [ACC_W-1:0] out_peak
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   bin_q [32];
    logic [4:0]         idx_q, idx_d;
    logic [ACC_W-1:0]   best_val_q, best_val_d;
    logic [4:0]         best_idx_q, best_idx_d;
    logic [4:0]         out_dir_q;
    logic [ACC_W-1:0]   out_peak_q;

    logic               accept;
    logic               clear;
    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   sat_sum;
    logic               scan_hit;
    logic               scan_end;

    assign accept   = in_valid && (state_q == S_ACC);
    assign clear    = (state_q == S_IDLE) && start;
    assign sum      = {1'b0, bin_q[in_dir]} + {{(ACC_W + 1 - MAG_W){1'b0}}, in_mag};
    assign sat_sum  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    assign scan_hit = bin_q[idx_q] > best_val_q;
    assign scan_end = (state_q == S_SCAN) && (idx_q == 5'd31);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACC;
            S_ACC:   if (accept && in_last) state_d = S_SCAN;
            S_SCAN:  if (idx_q == 5'd31) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  busy      = 1'b0;
            S_ACC:   in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Histogram bins: cleared on start, saturating add on each accepted sample
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int unsigned i = 0; i < 32; i++) begin
                bin_q[i] <= '0;
            end
        end else if (accept) begin
            bin_q[in_dir] <= sat_sum;
        end
    end

    // Scan index and running best, strict compare so the lowest index keeps a tie
    always_comb begin
        idx_d      = idx_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (clear) begin
            idx_d      = '0;
            best_val_d = '0;
            best_idx_d = '0;
        end else if (state_q == S_ACC) begin
            idx_d = '0;
        end else if (state_q == S_SCAN) begin
            idx_d = idx_q + 5'd1;
            if (scan_hit) begin
                best_val_d = bin_q[idx_q];
                best_idx_d = idx_q;
            end
        end
    end

    // Scan registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
        end else begin
            idx_q      <= idx_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    // Result registers load the final best on the last scan step, so they are
    // already valid during DONE and hold until the next window completes
    always_ff @(posedge clk) begin
        if (rst) begin
            out_dir_q  <= '0;
            out_peak_q <= '0;
        end else if (scan_end) begin
            out_dir_q  <= best_idx_d;
            out_peak_q <= best_val_d;
        end
    end

    assign out_dir  = out_dir_q;
    assign out_peak = out_peak_q;

endmodule

// File: tb/tb_ori_hist_peak.sv
// Self-checking bench for ori_hist_peak: directed windows plus randomized
// windows compared against a plain-arithmetic histogram model.
module tb_ori_hist_peak;

    localparam int MAG_W = 8;
    localparam int ACC_W = 16;
    localparam longint MAXV = (64'd1 << ACC_W) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_dir;
    logic [MAG_W-1:0] in_mag;
    logic             in_last;
    logic             busy;
    logic             out_valid;
    logic [4:0]       out_dir;
    logic [ACC_W-1:0] out_peak;

    int total = 0;
    int bad   = 0;

    int q_dir[$];
    int q_mag[$];

    ori_hist_peak #(.MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dir   (in_dir),
        .in_mag   (in_mag),
        .in_last  (in_last),
        .busy     (busy),
        .out_valid(out_valid),
        .out_dir  (out_dir),
        .out_peak (out_peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: saturating per-bin sums, then first maximum from index 0
    function automatic void model(output int exp_dir, output longint exp_peak);
        longint h[32];
        for (int i = 0; i < 32; i++) h[i] = 0;
        for (int k = 0; k < q_dir.size(); k++) begin
            h[q_dir[k]] = h[q_dir[k]] + q_mag[k];
            if (h[q_dir[k]] > MAXV) h[q_dir[k]] = MAXV;
        end
        exp_dir  = 0;
        exp_peak = h[0];
        for (int i = 1; i < 32; i++) begin
            if (h[i] > exp_peak) begin
                exp_peak = h[i];
                exp_dir  = i;
            end
        end
    endfunction

    // Runs one window from IDLE using q_dir/q_mag; optionally pulses start mid-scan
    task automatic run_window(input string tag, input int gap_pct, input bit scan_start);
        int     lat;
        int     exp_dir;
        longint exp_peak;
        model(exp_dir, exp_peak);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, "_ready_after_start"}, in_ready, 1);
        for (int k = 0; k < q_dir.size(); k++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_dir   = 5'($urandom_range(31));
                in_mag   = MAG_W'($urandom_range(255));
                in_last  = 1'($urandom_range(1));
                tick();
            end
            in_valid = 1'b1;
            in_dir   = 5'(q_dir[k]);
            in_mag   = MAG_W'(q_mag[k]);
            in_last  = (k == q_dir.size() - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq({tag, "_ready_after_last"}, in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            start = (scan_start && lat == 10);
            tick();
            start = 1'b0;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 33);
        check_eq({tag, "_dir"}, out_dir, exp_dir);
        check_eq({tag, "_peak"}, out_peak, 32'(exp_peak));
        tick();
        check_eq({tag, "_valid_pulse"}, out_valid, 0);
        check_eq({tag, "_busy_idle"}, busy, 0);
        check_eq({tag, "_hold_dir"}, out_dir, exp_dir);
        check_eq({tag, "_hold_peak"}, out_peak, 32'(exp_peak));
        if (scan_start) begin
            tick();
            tick();
            check_eq({tag, "_no_second_window"}, busy, 0);
        end
    endtask

    initial begin
        int n;
        int dmax;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_dir   = '0;
        in_mag   = '0;
        in_last  = 1'b0;

        // Reset and idle
        tick();
        check_eq("rst_ready", in_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_dir", out_dir, 0);
        check_eq("rst_peak", out_peak, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_dir   = 5'(i + 2);
            in_mag   = 8'd200;
            in_last  = (i == 3);
            tick();
            check_eq("idle_ready", in_ready, 0);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        q_dir = {0};
        q_mag = {0};
        run_window("empty", 0, 1'b0);

        // Single peak, back to back
        q_dir = {5, 5, 12, 5};
        q_mag = {10, 20, 25, 1};
        run_window("single", 0, 1'b0);

        // Tie with stalls, start during scan ignored
        q_dir = {3, 30};
        q_mag = {40, 40};
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_dir = 5'd3; in_mag = 8'd40; in_last = 1'b0;
        tick();
        in_valid = 1'b0; in_last = 1'b1;
        tick(); tick(); tick();
        check_eq("tie_stall_ready", in_ready, 1);
        // fall back to the generic window runner for the tie pattern with a scan-time start
        in_last = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_window("tie", 40, 1'b1);

        // Saturation
        q_dir.delete();
        q_mag.delete();
        for (int i = 0; i < 300; i++) begin
            q_dir.push_back(31);
            q_mag.push_back(255);
        end
        run_window("sat", 0, 1'b0);

        // Abort mid-ACC, then restart
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_dir = 5'd7; in_mag = 8'd50; in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", in_ready, 0);
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_dir", out_dir, 0);
        check_eq("abort_peak", out_peak, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) check_eq("abort_spurious_valid", out_valid, 0);
        end
        q_dir = {9};
        q_mag = {4};
        run_window("restart", 0, 1'b0);

        // Random windows; some restricted to few bins / small magnitudes to force ties
        for (int w = 0; w < 8; w++) begin
            q_dir.delete();
            q_mag.delete();
            n    = $urandom_range(256, 32);
            dmax = (w % 2 == 0) ? 31 : 3;
            for (int k = 0; k < n; k++) begin
                q_dir.push_back($urandom_range(dmax));
                q_mag.push_back((w % 2 == 0) ? $urandom_range(255) : $urandom_range(2));
            end
            run_window($sformatf("rand%0d", w), 30, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ori_hist_peak.md
# ori_hist_peak

Dominant-orientation stage for the keypoint orientation path. It takes the per-pixel 5-bit direction bins (0..31) from the direction lookup tables, weighted by gradient magnitude, and accumulates them into a 32-bin histogram over one keypoint window. After the window closes it scans the histogram and reports the peak bin and its value to the descriptor stage.

## Interface
Parameters:
- `MAG_W`, default 8: width of the gradient magnitude input.
- `ACC_W`, default 16: width of each histogram bin accumulator (must satisfy `ACC_W >= MAG_W`).

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begins a new window; sampled only in IDLE.
- `in_valid`, input, 1: sample valid.
- `in_ready`, output, 1: the block accepts samples; high only in ACC.
- `in_dir`, input, 5: direction bin 0..31 from the direction lookup.
- `in_mag`, input, `MAG_W`: magnitude weight, unsigned.
- `in_last`, input, 1: marks the final sample of the window; qualified by `in_valid & in_ready`.
- `busy`, output, 1: high in every state except IDLE.
- `out_valid`, output, 1: one-cycle pulse when the result is available.
- `out_dir`, output, 5: peak bin index.
- `out_peak`, output, `ACC_W`: peak bin value.

## Operation
- Storage: 32 registers `bin[0..31]`, each `ACC_W` wide. A scan counter `idx` is 5 bits wide (one extra terminal flag is allowed). `best_val` is `ACC_W` wide and `best_idx` is 5 bits wide.
- States: IDLE, ACC, SCAN, DONE.
- **IDLE:**
  - `start=1` clears all 32 bins, `best_val` and `best_idx`, then moves to ACC.
  - `in_valid` is ignored in IDLE.
- **ACC:**
  - `in_ready=1`.
  - On each accepted sample: `bin[in_dir] <= min(bin[in_dir] + in_mag, 2^ACC_W-1)`. The bin saturates and never wraps.
  - Back-to-back samples to the same bin must all accumulate. This holds naturally because all bins are registers with a single-cycle update, so no forwarding hazard exists.
  - An accepted sample with `in_last=1` is accumulated, then the state moves to SCAN with `idx=0`.
  - `in_valid=0` cycles are stalls with no change.
- **SCAN:**
  - Visits one bin per cycle, `idx` 0..31.
  - If `bin[idx] > best_val` (strict), then `best_val <= bin[idx]` and `best_idx <= idx`.
  - Ties therefore resolve to the lowest index.
  - After `idx=31` the state moves to DONE.
- **DONE:**
  - `out_valid=1` for exactly one cycle, with `out_dir=best_idx` and `out_peak=best_val`.
  - Next state is IDLE.
- `out_dir` and `out_peak` hold their last result until the next DONE.
- `start` outside IDLE is ignored; no queuing.
- An empty histogram (all zero magnitudes) reports `out_dir=0`, `out_peak=0`.
- A window may contain any number of samples ≥1. There is no internal sample count; `in_last` alone closes the window.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready=0`, `busy=0`, `out_valid=0`, `out_dir=0`, `out_peak=0`.
  - All bins, `best_val`, `best_idx` and `idx` are 0.
- `start` sampled at cycle S: ACC and `in_ready=1` from S+1.
- Last sample accepted at cycle T: `in_ready=0` from T+1. SCAN occupies T+1..T+32 (idx 0..31). DONE and `out_valid=1` at T+33. IDLE at T+34, so the earliest next `start` is accepted at T+34.
- Throughput: one sample per cycle in ACC. Fixed overhead of 34 cycles per window (1 for start, 33 after last).
- The histogram update is visible to the next cycle's accumulation of the same bin.
- `rst` asserted in any state, including mid-ACC or mid-SCAN: everything returns to reset values on the next edge, and no `out_valid` is produced for the aborted window.
- `in_last` together with `in_valid=0` has no effect.

## Test plan
- **Reset and idle:** assert `rst` for 2 cycles, then drive `in_valid=1` in IDLE without `start` → all outputs 0, no bins change, and a later empty window (`start`, then a single sample dir=0, mag=0, last) reports `out_dir=0`, `out_peak=0` at T+33.
- **Single peak:** `start`; samples (dir 5, mag 10), (dir 5, mag 20), (dir 12, mag 25), (dir 5, mag 1, last), sent back-to-back → `out_valid` exactly once, 33 cycles after the last sample, with `out_dir=5`, `out_peak=31`.
- **Tie and stalls:** dir 3 mag 40, stall 3 cycles, dir 30 mag 40 last → `out_dir=3`, `out_peak=40`. Then `start` is issued during SCAN and must be ignored: no second window, `busy` deasserts at T+34.
- **Saturation:** `ACC_W=16`, `MAG_W=8`; 300 samples of dir 31, mag 255 → `out_dir=31`, `out_peak=16'hFFFF`.
- **Abort and restart:** `rst` mid-ACC after 5 samples to dir 7, then a new window with one sample (dir 9, mag 4, last) → result `out_dir=9`, `out_peak=4`; bin 7 must show no residue.
- **Random windows:** 32–256 random (dir, mag) samples with random `in_valid` gaps → output matches a reference model using lowest-index tie-break and saturation; cycle count from last accept to `out_valid` is always 33.
